// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard command sequencer: runs the reset/BAT/LED init sequence, services LED
// updates with resend and timeout retries, and queues received scan codes in a FWFT FIFO.
module ps2_kbd_ctrl #(
  parameter int RESP_TIMEOUT = 1000000,
  parameter int BAT_TIMEOUT  = 50000000,
  parameter int MAX_RETRY    = 3,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] host_tx_data,
  output logic       host_tx_req,
  input  logic       host_tx_ready,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_ready,
  input  logic [2:0] led_val,
  input  logic       led_wr,
  output logic [7:0] key_data,
  output logic       key_valid,
  input  logic       key_rd,
  output logic       overflow,
  output logic       init_done,
  output logic       busy,
  output logic       error
);

  localparam int TMAX = (RESP_TIMEOUT > BAT_TIMEOUT) ? RESP_TIMEOUT : BAT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RW   = $clog2(MAX_RETRY + 2);
  // The timer holds the cycles remaining including the current one, so it expires on
  // exactly the TIMEOUT-th wait cycle.
  localparam logic [TW-1:0] RESP_LOAD = TW'(RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] BAT_LOAD  = TW'(BAT_TIMEOUT - 1);

  typedef enum logic [2:0] {SEND, WAIT_ACK, WAIT_RESP, WAIT_BAT, IDLE, ERROR} state_t;
  typedef enum logic [1:0] {STG_RST, STG_LED_CMD, STG_LED_ARG} stage_t;

  state_t         state_reg;
  stage_t         stage_reg;
  logic [7:0]     cmd_reg;
  logic [7:0]     tx_data_reg;
  logic           tx_req_reg;
  logic [2:0]     led_reg;
  logic [2:0]     led_snap_reg;
  logic           led_pending_reg;
  logic [RW-1:0]  retry_cnt_reg;
  logic [TW-1:0]  timer_reg;
  logic           init_done_reg;

  logic [2:0]     led_next;
  logic           push_req;
  logic           do_retry;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic [AW:0]    fifo_cnt;
  logic [AW-1:0]  rd_idx_next;
  logic [7:0]     head_reg;
  logic           overflow_reg;
  logic           fifo_empty;
  logic           fifo_full;
  logic           do_push;
  logic           do_pop;

  assign led_next = led_wr ? led_val : led_reg;

  // Protocol bytes are consumed only where the sequencer is waiting for them.
  always_comb begin
    push_req = 1'b0;
    if (host_rx_ready) begin
      case (state_reg)
        WAIT_RESP: push_req = (host_rx_data != 8'hFA) && (host_rx_data != 8'hFE);
        WAIT_BAT:  push_req = (host_rx_data != 8'hAA) && (host_rx_data != 8'hFC);
        default:   push_req = 1'b1;
      endcase
    end
  end

  always_comb begin
    do_retry = 1'b0;
    case (state_reg)
      WAIT_ACK:  do_retry = !host_tx_ready && (timer_reg == '0);
      WAIT_RESP: begin
        if (host_rx_ready && host_rx_data == 8'hFE)
          do_retry = 1'b1;
        else if (!(host_rx_ready && host_rx_data == 8'hFA) && timer_reg == '0)
          do_retry = 1'b1;
      end
      default: do_retry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= SEND;
      stage_reg       <= STG_RST;
      cmd_reg         <= 8'hFF;
      tx_data_reg     <= 8'h00;
      tx_req_reg      <= 1'b0;
      led_reg         <= 3'b000;
      led_snap_reg    <= 3'b000;
      led_pending_reg <= 1'b0;
      retry_cnt_reg   <= '0;
      timer_reg       <= '0;
      init_done_reg   <= 1'b0;
    end else begin
      if (led_wr) begin
        led_reg         <= led_val;
        led_pending_reg <= 1'b1;
      end
      if (timer_reg != '0 && (state_reg == WAIT_ACK || state_reg == WAIT_RESP ||
                              state_reg == WAIT_BAT))
        timer_reg <= timer_reg - TW'(1);

      case (state_reg)
        // Every entry into SEND raises the request; only the post-reset entry needs
        // one extra cycle to present it.
        SEND: begin
          if (!tx_req_reg) begin
            tx_req_reg  <= 1'b1;
            tx_data_reg <= cmd_reg;
          end else begin
            tx_req_reg <= 1'b0;
            timer_reg  <= RESP_LOAD;
            state_reg  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (host_tx_ready) begin
            timer_reg <= RESP_LOAD;
            state_reg <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (host_rx_ready && host_rx_data == 8'hFA) begin
            case (stage_reg)
              STG_RST: begin
                timer_reg <= BAT_LOAD;
                state_reg <= WAIT_BAT;
              end
              STG_LED_CMD: begin
                cmd_reg       <= {5'b0, led_snap_reg};
                tx_data_reg   <= {5'b0, led_snap_reg};
                tx_req_reg    <= 1'b1;
                retry_cnt_reg <= '0;
                stage_reg     <= STG_LED_ARG;
                state_reg     <= SEND;
              end
              default: state_reg <= IDLE;
            endcase
          end
        end
        WAIT_BAT: begin
          if (host_rx_ready && host_rx_data == 8'hAA) begin
            init_done_reg   <= 1'b1;
            led_snap_reg    <= led_next;
            led_pending_reg <= 1'b0;
            cmd_reg         <= 8'hED;
            tx_data_reg     <= 8'hED;
            tx_req_reg      <= 1'b1;
            retry_cnt_reg   <= '0;
            stage_reg       <= STG_LED_CMD;
            state_reg       <= SEND;
          end else if (host_rx_ready && host_rx_data == 8'hFC) begin
            state_reg <= ERROR;
          end else if (timer_reg == '0) begin
            state_reg <= ERROR;
          end
        end
        IDLE: begin
          if (led_pending_reg || led_wr) begin
            led_pending_reg <= 1'b0;
            led_snap_reg    <= led_next;
            cmd_reg         <= 8'hED;
            tx_data_reg     <= 8'hED;
            tx_req_reg      <= 1'b1;
            retry_cnt_reg   <= '0;
            stage_reg       <= STG_LED_CMD;
            state_reg       <= SEND;
          end
        end
        default: ;
      endcase

      if (do_retry) begin
        if (retry_cnt_reg < RW'(MAX_RETRY)) begin
          retry_cnt_reg <= retry_cnt_reg + RW'(1);
          tx_data_reg   <= cmd_reg;
          tx_req_reg    <= 1'b1;
          state_reg     <= SEND;
        end else begin
          state_reg <= ERROR;
        end
      end
    end
  end

  assign fifo_cnt    = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign do_pop      = key_rd && !fifo_empty;
  assign do_push     = push_req && (!fifo_full || do_pop);
  assign rd_idx_next = rd_ptr_reg[AW-1:0] + AW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      fifo_mem[wr_ptr_reg[AW-1:0]] <= host_rx_data;
  end

  // key_data is a registered copy of the head; a push into a draining FIFO bypasses memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      head_reg     <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (push_req && fifo_full && !do_pop)
        overflow_reg <= 1'b1;
      if (do_push && (fifo_empty || (do_pop && fifo_cnt == (AW+1)'(1))))
        head_reg <= host_rx_data;
      else
        head_reg <= fifo_mem[rd_idx_next];
    end
  end

  assign host_tx_data = tx_data_reg;
  assign host_tx_req  = tx_req_reg;
  assign key_data     = head_reg;
  assign key_valid    = !fifo_empty;
  assign overflow     = overflow_reg;
  assign init_done    = init_done_reg;
  assign busy         = (state_reg != IDLE) && (state_reg != ERROR);
  assign error        = (state_reg == ERROR);

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a scripted keyboard answers each transmitted byte,
// and transmitted bytes, status flags and FIFO output are compared with hand-computed values.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] host_tx_data;
  logic       host_tx_req;
  logic       host_tx_ready = 1'b0;
  logic [7:0] host_rx_data = 8'h00;
  logic       host_rx_ready = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic       led_wr = 1'b0;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_rd = 1'b0;
  logic       overflow;
  logic       init_done;
  logic       busy;
  logic       error;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_tx_cyc = 0;

  ps2_kbd_ctrl #(
    .RESP_TIMEOUT(100),
    .BAT_TIMEOUT (300),
    .MAX_RETRY   (3),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host_tx_data (host_tx_data),
    .host_tx_req  (host_tx_req),
    .host_tx_ready(host_tx_ready),
    .host_rx_data (host_rx_data),
    .host_rx_ready(host_rx_ready),
    .led_val      (led_val),
    .led_wr       (led_wr),
    .key_data     (key_data),
    .key_valid    (key_valid),
    .key_rd       (key_rd),
    .overflow     (overflow),
    .init_done    (init_done),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a transmit request and checks the byte presented with it.
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!host_tx_req && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_req"}, 32'(host_tx_req), 32'd1);
    check_eq(tag, 32'(host_tx_data), 32'(exp));
    last_tx_cyc = cyc;
    $display("tx %s: byte 0x%02h at cycle %0d", tag, host_tx_data, cyc);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    host_tx_ready = 1'b1;
    @(negedge clk);
    host_tx_ready = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    host_rx_data  = b;
    host_rx_ready = 1'b1;
    @(negedge clk);
    host_rx_ready = 1'b0;
    $display("rx byte 0x%02h at cycle %0d", b, cyc);
  endtask

  task automatic write_led(input logic [2:0] v);
    @(negedge clk);
    led_val = v;
    led_wr  = 1'b1;
    @(negedge clk);
    led_wr  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, 32'(key_valid), 32'd1);
    check_eq(tag, 32'(key_data), 32'(exp));
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_req", 32'(host_tx_req), 32'd0);
    check_eq("rst_tx_data", 32'(host_tx_data), 32'h00);
    check_eq("rst_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
  endtask

  task automatic run_init();
    expect_tx("init_ff", 8'hFF);
    pulse_ack();
    send_rx(8'hFA);
    check_eq("init_done_early", 32'(init_done), 32'd0);
    send_rx(8'hAA);
    check_eq("init_done_bat", 32'(init_done), 32'd1);
    expect_tx("init_ed", 8'hED);
    pulse_ack();
    send_rx(8'hFA);
    expect_tx("init_led", 8'h00);
    pulse_ack();
    send_rx(8'hFA);
    @(negedge clk);
    check_eq("init_busy", 32'(busy), 32'd0);
    check_eq("init_fifo_empty", 32'(key_valid), 32'd0);
    check_eq("init_error", 32'(error), 32'd0);
  endtask

  initial begin
    int reqs;
    int t0;

    do_reset();
    run_init();

    // Resend of the first 0xED
    write_led(3'b010);
    expect_tx("resend_ed1", 8'hED);
    pulse_ack();
    send_rx(8'hFE);
    expect_tx("resend_ed2", 8'hED);
    pulse_ack();
    send_rx(8'hFA);
    expect_tx("resend_arg", 8'h02);
    pulse_ack();
    send_rx(8'hFA);
    @(negedge clk);
    check_eq("resend_busy", 32'(busy), 32'd0);
    check_eq("resend_error", 32'(error), 32'd0);

    // LED coalescing, plus a scan code arriving mid-command
    write_led(3'b100);
    expect_tx("coal_ed1", 8'hED);
    pulse_ack();
    write_led(3'b011);
    send_rx(8'h5A);
    pop_check("coal_scan", 8'h5A);
    check_eq("coal_fifo_empty", 32'(key_valid), 32'd0);
    send_rx(8'hFA);
    expect_tx("coal_arg1", 8'h04);
    pulse_ack();
    send_rx(8'hFA);
    expect_tx("coal_ed2", 8'hED);
    pulse_ack();
    send_rx(8'hFA);
    expect_tx("coal_arg2", 8'h03);
    pulse_ack();
    send_rx(8'hFA);
    @(negedge clk);
    check_eq("coal_busy", 32'(busy), 32'd0);
    check_eq("coal_fifo_empty2", 32'(key_valid), 32'd0);

    // Overflow: nine pushes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send_rx(8'(i));
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) pop_check("ovf_read", 8'(i));
    check_eq("ovf_drained", 32'(key_valid), 32'd0);

    // Full FIFO with push and pop in the same cycle
    do_reset();
    run_init();
    for (int i = 0; i < 8; i++) send_rx(8'h10 + 8'(i));
    check_eq("full_no_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    key_rd        = 1'b1;
    host_rx_data  = 8'h18;
    host_rx_ready = 1'b1;
    @(negedge clk);
    key_rd        = 1'b0;
    host_rx_ready = 1'b0;
    check_eq("simul_no_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) pop_check("simul_read", 8'h10 + 8'(i));
    check_eq("simul_drained", 32'(key_valid), 32'd0);
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
    send_rx(8'h55);
    check_eq("empty_pop_valid", 32'(key_valid), 32'd1);
    check_eq("empty_pop_data", 32'(key_data), 32'h55);

    // Retries exhausted on 0xFF
    do_reset();
    for (int k = 0; k < 4; k++) begin
      expect_tx("retry_ff", 8'hFF);
      pulse_ack();
      send_rx(8'hFE);
    end
    check_eq("retry_error", 32'(error), 32'd1);
    check_eq("retry_busy", 32'(busy), 32'd0);
    check_eq("retry_init_done", 32'(init_done), 32'd0);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (host_tx_req) reqs++;
    end
    check_eq("retry_no_more_tx", 32'(reqs), 32'd0);
    send_rx(8'h1C);
    check_eq("err_rx_valid", 32'(key_valid), 32'd1);
    check_eq("err_rx_data", 32'(key_data), 32'h1C);

    // BAT failure
    do_reset();
    expect_tx("bat_ff", 8'hFF);
    pulse_ack();
    send_rx(8'hFA);
    send_rx(8'hFC);
    check_eq("bat_error", 32'(error), 32'd1);
    check_eq("bat_init_done", 32'(init_done), 32'd0);
    check_eq("bat_busy", 32'(busy), 32'd0);

    // ACK timeout: SEND cycle plus 100 WAIT_ACK cycles between requests
    do_reset();
    expect_tx("tmo_ff1", 8'hFF);
    t0 = last_tx_cyc;
    @(negedge clk);
    expect_tx("tmo_ff2", 8'hFF);
    check_eq("tmo_gap", 32'(last_tx_cyc - t0), 32'd101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Command sequencer and receive buffer that sits between the CPU-side I/O registers and the ps2_host byte transceiver.
- After reset, runs the keyboard init sequence: reset command 0xFF, wait for ACK 0xFA, wait for BAT 0xAA, then program the LEDs.
- At runtime, services LED-update requests as the two-byte command 0xED + LED byte.
- Handles resend (0xFE) and timeout retries.
- Queues every non-protocol received byte into a scan-code FIFO for the CPU.

Parameters:
RESP_TIMEOUT, 1000000, clk cycles allowed from tx_req to ACK, and from ACK to response byte
BAT_TIMEOUT, 50000000, clk cycles allowed from ACK of 0xFF to the BAT byte
MAX_RETRY, 3, retransmissions allowed per command byte before error
FIFO_DEPTH, 8, scan-code FIFO entries; must be a power of 2

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
host_tx_data  out  8  byte presented to ps2_host
host_tx_req  out  1  transmit request; ps2_host acts on its rising edge
host_tx_ready  in  1  one-cycle pulse from ps2_host: device ACK bit detected
host_rx_data  in  8  received byte
host_rx_ready  in  1  one-cycle pulse: host_rx_data valid
led_val  in  3  [0] scroll, [1] num, [2] caps
led_wr  in  1  one-cycle strobe: latch led_val and schedule an LED update
key_data  out  8  FIFO head (first-word-fall-through)
key_valid  out  1  FIFO not empty
key_rd  in  1  pop FIFO head; ignored when key_valid=0
overflow  out  1  sticky: a byte was dropped because the FIFO was full
init_done  out  1  init sequence completed successfully
busy  out  1  command in progress (state not IDLE/ERROR)
error  out  1  sticky: retries exhausted or BAT failure

Behaviour:
- Reset values: host_tx_data=0x00, host_tx_req=0, key_valid=0, overflow=0, init_done=0, busy=1, error=0; FIFO empty; led register=0; led_pending=0; retry_cnt=0; state=SEND with cmd=0xFF, stage=RST.
- Reset mid-operation aborts any command immediately and restarts the init sequence; FIFO contents are discarded.
- States: SEND, WAIT_ACK, WAIT_RESP, WAIT_BAT, IDLE, ERROR.
- SEND (1 cycle):
  - host_tx_data=cmd and host_tx_req=1 for exactly this cycle; host_tx_req is 0 in every other state.
  - Load timer=RESP_TIMEOUT, go to WAIT_ACK.
- WAIT_ACK:
  - On host_tx_ready: timer=RESP_TIMEOUT (stage RST: BAT_TIMEOUT is used later in WAIT_BAT), go to WAIT_RESP.
  - On timer==0: retry.
- WAIT_RESP, on host_rx_ready:
  - 0xFA, stage RST: timer=BAT_TIMEOUT, go to WAIT_BAT.
  - 0xFA, stage LED_CMD: cmd={5'b0, led}, stage=LED_ARG, go to SEND, retry_cnt=0.
  - 0xFA, stage LED_ARG: go to IDLE.
  - 0xFE: retry.
  - Any other byte: pushed to FIFO; state unchanged.
  - On timer==0: retry.
- WAIT_BAT, on host_rx_ready:
  - 0xAA: init_done=1; stage=LED_CMD, cmd=0xED, go to SEND.
  - 0xFC: go to ERROR.
  - Other bytes: pushed to FIFO.
  - On timer==0: go to ERROR.
- Retry:
  - If retry_cnt<MAX_RETRY: retry_cnt+1, go to SEND with the same cmd.
  - Otherwise go to ERROR.
  - retry_cnt clears whenever a new cmd byte is loaded.
- IDLE:
  - If led_pending: clear led_pending, stage=LED_CMD, cmd=0xED, go to SEND.
  - Every host_rx_ready byte is pushed to FIFO (protocol bytes included).
- ERROR:
  - error=1, busy=0; held until rst.
  - Received bytes are still pushed to FIFO; led_wr is latched but never serviced.
- led_wr (any state): led<=led_val, led_pending<=1.
  - Multiple writes during a command coalesce; the latest value is sent.
  - led_wr in IDLE starts SEND on the next cycle.
- LED_ARG sends the led register value as of the cycle SEND was entered.
- FIFO:
  - Push and pop complete in one cycle.
  - Push when full: byte dropped, overflow<=1, unless key_rd pops in the same cycle, in which case both occur.
  - Pop when empty is ignored.
  - Pushed byte is visible on key_data/key_valid the cycle after host_rx_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Timer: down-counter sized for max(RESP_TIMEOUT, BAT_TIMEOUT); decrements in WAIT_* states, saturates at 0.
- host_rx_ready in WAIT_ACK or SEND: byte pushed to FIFO.

Test Plan:
- Init, normal: after rst, device model ACKs 0xFF, returns 0xFA, then 0xAA -> host_tx_data sequence FF, ED, 00; init_done=1 after 0xAA; IDLE with busy=0; FIFO empty.
- Resend: device answers first 0xED with 0xFE -> 0xED retransmitted; FA, FA completes; retry_cnt reaches 1; error=0.
- Retries exhausted: 0xFF answered with 0xFE four times (MAX_RETRY=3) -> four transmissions of 0xFF, then error=1, busy=0; later rx byte 0x1C still appears on key_data.
- LED update with coalescing: in IDLE, led_wr with led_val=3'b100; second led_wr with 3'b011 during WAIT_RESP -> bytes ED,04 then ED,03; busy=0 afterwards.
- FIFO overflow and simultaneous push/pop: 9 bytes 0x01..0x09 with no reads -> overflow=1; reads return 01..08 then key_valid=0. Full FIFO with key_rd and rx in the same cycle -> no overflow; new byte kept.
- Faults: BAT byte 0xFC -> error=1, init_done=0. No response for RESP_TIMEOUT cycles (set to 100 in sim) -> 0xFF retransmitted after exactly 100 WAIT_ACK cycles.
